// File: rtl/sata_fis_data_sched.sv
// rtl/sata_fis_data_sched.sv - Data FIS frame sequencer for one ATA DMA transfer
module sata_fis_data_sched #(
    parameter int MAX_DWORDS = 2048,
    parameter int LEN_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [LEN_WIDTH-1:0] cmd_dwords,
    input  logic                 cmd_wait_act,
    output logic                 cmd_ready,
    input  logic                 act_valid,
    input  logic                 abort,
    output logic                 ctl_valid,
    output logic [10:0]          ctl_count,
    input  logic                 ctl_ready,
    output logic                 busy,
    output logic                 done,
    output logic                 done_aborted,
    output logic [15:0]          frm_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_ACT = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT_FRM = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_DWORDS);

    logic [2:0]           state;
    logic [LEN_WIDTH-1:0] rem;
    logic                 wait_act;
    logic                 act_pend;
    logic                 abort_flag;
    logic [LEN_WIDTH-1:0] cur_len;
    logic                 abort_any;
    logic                 act_any;

    // Length of the frame that would be issued now: capped at MAX_DWORDS.
    always_comb begin
        cur_len = rem;
        if (rem > MAX_LEN) begin
            cur_len = MAX_LEN;
        end
    end

    // An abort seen this cycle counts the same as one seen earlier in the transfer.
    assign abort_any = abort_flag | abort;
    assign act_any   = act_pend | act_valid;

    // All outputs decode from registered state only; 2048 truncates to 0 in 11 bits.
    assign cmd_ready    = (state == S_IDLE);
    assign busy         = (state != S_IDLE);
    assign ctl_valid    = (state == S_ISSUE);
    assign ctl_count    = (state == S_ISSUE) ? cur_len[10:0] : 11'd0;
    assign done         = (state == S_DONE);
    assign done_aborted = (state == S_DONE) & abort_flag;

    // Transfer sequencing FSM with activate and abort bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            rem        <= '0;
            wait_act   <= 1'b0;
            act_pend   <= 1'b0;
            abort_flag <= 1'b0;
            frm_cnt    <= 16'd0;
        end else begin
            // Activates arriving outside WAIT_ACT are remembered once; extras are dropped.
            if ((state != S_IDLE) && (state != S_WAIT_ACT) && act_valid) begin
                act_pend <= 1'b1;
            end
            if ((state != S_IDLE) && abort) begin
                abort_flag <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rem        <= cmd_dwords;
                        wait_act   <= cmd_wait_act;
                        frm_cnt    <= 16'd0;
                        act_pend   <= 1'b0;
                        abort_flag <= 1'b0;
                        if (cmd_dwords == '0) begin
                            state <= S_DONE;
                        end else if (cmd_wait_act) begin
                            state <= S_WAIT_ACT;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_WAIT_ACT: begin
                    if (abort_any) begin
                        state <= S_DONE;
                    end else if (act_any) begin
                        act_pend <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // A transfer already offered completes even if abort arrives with it.
                    if (ctl_ready) begin
                        rem <= rem - cur_len;
                        if (frm_cnt != 16'hFFFF) begin
                            frm_cnt <= frm_cnt + 16'd1;
                        end
                        state <= S_WAIT_FRM;
                    end else if (abort_any) begin
                        state <= S_DONE;
                    end
                end
                S_WAIT_FRM: begin
                    if (ctl_ready) begin
                        if ((rem == '0) || abort_any) begin
                            state <= S_DONE;
                        end else if (!wait_act) begin
                            state <= S_ISSUE;
                        end else if (act_any) begin
                            // A banked activate lets the next frame go out without a WAIT_ACT cycle.
                            act_pend <= 1'b0;
                            state    <= S_ISSUE;
                        end else begin
                            state <= S_WAIT_ACT;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
